// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end: FSM states, word width, PC stride
// and the {pc, instr} entry carried through the fetch buffer.
package fetch_pkg;

  localparam int          INSTR_W = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DONE  = 2'd1,
    ERROR = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of fetched {pc, instr} entries with flush; head visible combinationally.
// Push on a full buffer is accepted only alongside a pop; flush wins over push and pop.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  fetch_entry_t           push_dat,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head_dat,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  fetch_entry_t     head_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_push = push & (~full | pop) & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head_q <= '0;
    end else begin
      // Remember the last presented head so outputs hold once the buffer empties.
      if (!empty) begin
        head_q <= mem[rd_ptr];
      end
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({do_push, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  assign head_dat = empty ? head_q : mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: drives PC, captures the combinational word, queues it for decode.
// First word valid one cycle after reset; 1 word/cycle; stalls PC when the buffer is full.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 36,
  parameter int          BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic [31:0]        PC,
  input  logic [INSTR_W-1:0] Instruction_Code,
  input  logic               Jump,
  input  logic [31:0]        Jump_Target,
  output logic               Instr_Valid,
  input  logic               Instr_Ready,
  output logic [INSTR_W-1:0] Instr_Out,
  output logic [31:0]        Instr_PC,
  output logic               Fetch_Done,
  output logic               Fetch_Error
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);
  localparam logic [31:0]      LAST_PC  = 32'(MEM_BYTES - 4);

  fetch_state_t     state_q;
  fetch_state_t     state_d;
  logic [31:0]      pc_q;
  logic [31:0]      pc_d;
  logic [31:0]      pc_inc;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic             flush;
  fetch_entry_t     push_dat;
  fetch_entry_t     head_dat;

  assign pc_inc   = pc_q + PC_STEP;
  assign push_dat = '{pc: pc_q, instr: Instruction_Code};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush   = 1'b0;
    pop     = Instr_Valid & Instr_Ready;
    push    = (state_q == FETCH) & ((count < FULL_CNT) | pop) & ~Jump;
    // A redirect outranks everything except a latched error.
    if (Jump && (state_q != ERROR)) begin
      flush = 1'b1;
      if (Jump_Target[1:0] != 2'b00) begin
        state_d = ERROR;
      end else begin
        pc_d    = Jump_Target;
        state_d = (Jump_Target > LAST_PC) ? DONE : FETCH;
      end
    end else if (push) begin
      pc_d = pc_inc;
      if (pc_inc > LAST_PC) begin
        state_d = DONE;
      end
    end
  end

  fetch_buffer #(
    .DEPTH(BUF_DEPTH)
  ) u_fetch_buffer (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .flush    (flush),
    .head_dat (head_dat),
    .count    (count)
  );

  assign PC          = pc_q;
  assign Instr_Valid = (count != '0);
  assign Instr_Out   = head_dat.instr;
  assign Instr_PC    = head_dat.pc;
  assign Fetch_Done  = (state_q == DONE);
  assign Fetch_Error = (state_q == ERROR);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit against a 36-byte instruction memory model.
module tb_instruction_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC;
  logic [31:0] Instruction_Code;
  logic        Jump;
  logic [31:0] Jump_Target;
  logic        Instr_Valid;
  logic        Instr_Ready;
  logic [31:0] Instr_Out;
  logic [31:0] Instr_PC;
  logic        Fetch_Done;
  logic        Fetch_Error;

  logic [31:0]  mem [0:8];
  fetch_entry_t exp_q [$];
  fetch_entry_t e;
  int           errors = 0;
  int           checks = 0;

  instruction_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .MEM_BYTES(36),
    .BUF_DEPTH(2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .PC              (PC),
    .Instruction_Code(Instruction_Code),
    .Jump            (Jump),
    .Jump_Target     (Jump_Target),
    .Instr_Valid     (Instr_Valid),
    .Instr_Ready     (Instr_Ready),
    .Instr_Out       (Instr_Out),
    .Instr_PC        (Instr_PC),
    .Fetch_Done      (Fetch_Done),
    .Fetch_Error     (Fetch_Error)
  );

  always #5 clk = ~clk;

  // Out-of-image addresses return a poison word so any stray delivery is visible.
  always_comb begin
    Instruction_Code = 32'hDEAD_BEEF;
    if (PC <= 32'd32 && PC[1:0] == 2'b00) Instruction_Code = mem[PC[5:2]];
  end

  function automatic fetch_entry_t mk(input logic [31:0] pc);
    fetch_entry_t r;
    r.pc    = pc;
    r.instr = mem[pc[5:2]];
    return r;
  endfunction

  task automatic test_reset();
    #1;
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h, required 0", PC); end
    checks++; if (Instr_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", Instr_Valid); end
    checks++; if (Instr_Out !== 32'h0) begin errors++; $display("FAIL reset_out: got %h, required 0", Instr_Out); end
    checks++; if (Instr_PC !== 32'h0) begin errors++; $display("FAIL reset_ipc: got %h, required 0", Instr_PC); end
    checks++; if (Fetch_Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", Fetch_Done); end
    checks++; if (Fetch_Error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b, required 0", Fetch_Error); end
  endtask

  task automatic test_stream();
    @(negedge clk);
    Instr_Ready = 1'b1;
    reset = 1'b1;
    for (int a = 0; a <= 32; a += 4) exp_q.push_back(mk(32'(a)));
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk); #1;
      checks++; if (Instr_Valid !== (k <= 9)) begin errors++; $display("FAIL stream_valid k=%0d: got %b, required %b", k, Instr_Valid, (k <= 9)); end
      checks++; if (Fetch_Done !== (k >= 9)) begin errors++; $display("FAIL stream_done k=%0d: got %b, required %b", k, Fetch_Done, (k >= 9)); end
      if (Instr_Valid && Instr_Ready && !Jump) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL stream_pop: got pc=%h instr=%h, required none", Instr_PC, Instr_Out); end
        else begin
          e = exp_q.pop_front();
          if (Instr_PC !== e.pc || Instr_Out !== e.instr) begin errors++; $display("FAIL stream_pop: got pc=%h instr=%h, required pc=%h instr=%h", Instr_PC, Instr_Out, e.pc, e.instr); end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stream_drain: got %0d left, required 0", exp_q.size()); end
    checks++; if (Instr_PC !== 32'd32) begin errors++; $display("FAIL stream_hold_ipc: got %h, required 20", Instr_PC); end
    checks++; if (PC !== 32'd36) begin errors++; $display("FAIL stream_pc_hold: got %h, required 24", PC); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    reset = 1'b0; Instr_Ready = 1'b0; exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    checks++; if (PC !== 32'd8) begin errors++; $display("FAIL bp_pc: got %h, required 8", PC); end
    checks++; if (Instr_Valid !== 1'b1 || Instr_PC !== 32'd0) begin errors++; $display("FAIL bp_head: got valid=%b pc=%h, required valid=1 pc=0", Instr_Valid, Instr_PC); end
    for (int a = 0; a <= 32; a += 4) exp_q.push_back(mk(32'(a)));
    Instr_Ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      checks++; if (Instr_Valid !== (k <= 8)) begin errors++; $display("FAIL bp_valid k=%0d: got %b, required %b", k, Instr_Valid, (k <= 8)); end
      if (Instr_Valid && Instr_Ready && !Jump) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL bp_pop: got pc=%h instr=%h, required none", Instr_PC, Instr_Out); end
        else begin
          e = exp_q.pop_front();
          if (Instr_PC !== e.pc || Instr_Out !== e.instr) begin errors++; $display("FAIL bp_pop: got pc=%h instr=%h, required pc=%h instr=%h", Instr_PC, Instr_Out, e.pc, e.instr); end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_jump();
    @(negedge clk);
    reset = 1'b0; exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back(mk(32'd0));
    @(negedge clk); #1;
    checks++;
    if (!(Instr_Valid && Instr_Ready)) begin errors++; $display("FAIL jump_first: got valid=%b, required 1", Instr_Valid); end
    else begin
      e = exp_q.pop_front();
      if (Instr_PC !== e.pc || Instr_Out !== e.instr) begin errors++; $display("FAIL jump_first: got pc=%h instr=%h, required pc=%h instr=%h", Instr_PC, Instr_Out, e.pc, e.instr); end
    end
    @(negedge clk);
    Jump = 1'b1; Jump_Target = 32'd8;
    #1;
    checks++; if (Instr_Valid !== 1'b1 || Instr_PC !== 32'd4) begin errors++; $display("FAIL jump_head: got valid=%b pc=%h, required valid=1 pc=4", Instr_Valid, Instr_PC); end
    @(negedge clk);
    Jump = 1'b0;
    #1;
    checks++; if (Instr_Valid !== 1'b0) begin errors++; $display("FAIL jump_flush: got %b, required 0", Instr_Valid); end
    checks++; if (PC !== 32'd8) begin errors++; $display("FAIL jump_pc: got %h, required 8", PC); end
    for (int a = 8; a <= 32; a += 4) exp_q.push_back(mk(32'(a)));
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk); #1;
      if (Instr_Valid && Instr_Ready && !Jump) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL jump_pop: got pc=%h instr=%h, required none", Instr_PC, Instr_Out); end
        else begin
          e = exp_q.pop_front();
          if (Instr_PC !== e.pc || Instr_Out !== e.instr) begin errors++; $display("FAIL jump_pop: got pc=%h instr=%h, required pc=%h instr=%h", Instr_PC, Instr_Out, e.pc, e.instr); end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL jump_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_done_redirect();
    @(negedge clk); #1;
    checks++; if (Fetch_Done !== 1'b1) begin errors++; $display("FAIL done_before: got %b, required 1", Fetch_Done); end
    Jump = 1'b1; Jump_Target = 32'd4;
    @(negedge clk);
    Jump = 1'b0;
    #1;
    checks++; if (Fetch_Done !== 1'b0) begin errors++; $display("FAIL done_cleared: got %b, required 0", Fetch_Done); end
    checks++; if (Instr_Valid !== 1'b0) begin errors++; $display("FAIL done_flush: got %b, required 0", Instr_Valid); end
    for (int a = 4; a <= 32; a += 4) exp_q.push_back(mk(32'(a)));
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk); #1;
      if (Instr_Valid && Instr_Ready && !Jump) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL done_pop: got pc=%h instr=%h, required none", Instr_PC, Instr_Out); end
        else begin
          e = exp_q.pop_front();
          if (Instr_PC !== e.pc || Instr_Out !== e.instr) begin errors++; $display("FAIL done_pop: got pc=%h instr=%h, required pc=%h instr=%h", Instr_PC, Instr_Out, e.pc, e.instr); end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL done_drain: got %0d left, required 0", exp_q.size()); end
    @(negedge clk);
    Jump = 1'b1; Jump_Target = 32'd40;
    @(negedge clk);
    Jump = 1'b0;
    #1;
    checks++; if (Fetch_Done !== 1'b1) begin errors++; $display("FAIL far_done: got %b, required 1", Fetch_Done); end
    checks++; if (PC !== 32'd40) begin errors++; $display("FAIL far_pc: got %h, required 28", PC); end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      checks++; if (Instr_Valid !== 1'b0) begin errors++; $display("FAIL far_valid k=%0d: got %b, required 0", k, Instr_Valid); end
    end
  endtask

  task automatic test_error();
    @(negedge clk);
    Jump = 1'b1; Jump_Target = 32'd6;
    @(negedge clk);
    Jump = 1'b0;
    #1;
    checks++; if (Fetch_Error !== 1'b1) begin errors++; $display("FAIL err_set: got %b, required 1", Fetch_Error); end
    checks++; if (PC !== 32'd40) begin errors++; $display("FAIL err_pc_hold: got %h, required 28", PC); end
    checks++; if (Fetch_Done !== 1'b0) begin errors++; $display("FAIL err_done: got %b, required 0", Fetch_Done); end
    @(negedge clk);
    Jump = 1'b1; Jump_Target = 32'd0;
    @(negedge clk);
    Jump = 1'b0;
    #1;
    checks++; if (Fetch_Error !== 1'b1 || PC !== 32'd40) begin errors++; $display("FAIL err_ignore_jump: got err=%b pc=%h, required err=1 pc=28", Fetch_Error, PC); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      checks++; if (Instr_Valid !== 1'b0) begin errors++; $display("FAIL err_valid k=%0d: got %b, required 0", k, Instr_Valid); end
    end
    @(negedge clk);
    reset = 1'b0; Instr_Ready = 1'b0;
    #1;
    checks++; if (Fetch_Error !== 1'b0 || PC !== 32'd0) begin errors++; $display("FAIL err_reset: got err=%b pc=%h, required err=0 pc=0", Fetch_Error, PC); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    checks++; if (Instr_Valid !== 1'b1 || Instr_PC !== 32'd0 || Instr_Out !== 32'h00940333) begin errors++; $display("FAIL err_restart: got valid=%b pc=%h instr=%h, required valid=1 pc=0 instr=00940333", Instr_Valid, Instr_PC, Instr_Out); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    reset = 1'b0; exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    Jump = 1'b1; Jump_Target = 32'd28;
    @(negedge clk);
    Jump = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    checks++; if (Fetch_Done !== 1'b1 || Instr_Valid !== 1'b1 || PC !== 32'd36) begin errors++; $display("FAIL areset_pre: got done=%b valid=%b pc=%h, required done=1 valid=1 pc=24", Fetch_Done, Instr_Valid, PC); end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (Instr_Valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b, required 0", Instr_Valid); end
    checks++; if (PC !== 32'd0) begin errors++; $display("FAIL areset_pc: got %h, required 0", PC); end
    checks++; if (Fetch_Done !== 1'b0) begin errors++; $display("FAIL areset_done: got %b, required 0", Fetch_Done); end
    checks++; if (Instr_PC !== 32'd0 || Instr_Out !== 32'd0) begin errors++; $display("FAIL areset_head: got pc=%h instr=%h, required 0 0", Instr_PC, Instr_Out); end
  endtask

  initial begin
    mem[0] = 32'h00940333;
    mem[1] = 32'h413903b3;
    mem[2] = 32'h035a02b3;
    mem[3] = 32'h037b4e33;
    for (int i = 4; i <= 8; i++) mem[i] = 32'h0;
    reset       = 1'b0;
    Jump        = 1'b0;
    Jump_Target = 32'h0;
    Instr_Ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_jump();
    test_done_redirect();
    test_error();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
